rr_mux_arb: RTL and testbench
=============================

Name: rr_mux_arb

Overview:
- Round-robin arbiter and sequencer for the shared 8-bit 2:1 mux datapath.
- Two requesters (A, B) each present data with a valid/ready handshake.
- The block picks one requester, steers the mux select, and captures the selected byte into a one-entry output register with its own valid/ready handshake.
- It also keeps saturating per-requester grant counters for debug and fairness checks.

Parameters:
- WIDTH, 8, data width of each requester and of the output.
- CNT_W, 16, width of each grant counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- a_valid_i  in  1  requester A has data.
- a_data_i  in  WIDTH  requester A data.
- a_ready_o  out  1  A's data is accepted this cycle.
- b_valid_i  in  1  requester B has data.
- b_data_i  in  WIDTH  requester B data.
- b_ready_o  out  1  B's data is accepted this cycle.
- y_valid_o  out  1  the output register holds valid data.
- y_data_o  out  WIDTH  registered mux output.
- y_ready_i  in  1  downstream accepts y_data_o this cycle.
- sel_o  out  1  source of the byte currently in y_data_o (0 = A, 1 = B), registered.
- a_cnt_o  out  CNT_W  number of grants to A, saturating.
- b_cnt_o  out  CNT_W  number of grants to B, saturating.

Behaviour:
- Reset values, applied on any clock edge where rst_i=1:
  - y_valid_o=0, y_data_o=0, sel_o=0.
  - a_cnt_o=0, b_cnt_o=0.
  - Internal last-grant pointer = B, so A wins the first tie.
- Output-register states:
  - EMPTY = y_valid_o is 0; FULL = y_valid_o is 1.
  - load_en = !y_valid_o || y_ready_i, computed combinationally.
- Arbitration, combinational, evaluated only when load_en=1:
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester that is not the last-grant pointer.
  - Neither valid: no grant.
- Ready outputs:
  - a_ready_o = load_en && grant==A; b_ready_o = load_en && grant==B.
  - Never both 1 in the same cycle.
  - Ready may depend combinationally on y_ready_i and the valid inputs.
  - Ready never depends on a requester's own ready.
- Actions on a grant:
  - Next edge: y_data_o <= granted data, sel_o <= grant, y_valid_o <= 1.
  - Last-grant pointer <= grant.
  - The granted counter increments by 1, stopping at 2^CNT_W-1 (no wrap).
- Transitions:
  - EMPTY -> FULL on a grant.
  - FULL with y_ready_i=1 and a grant: stays FULL with the new data; back-to-back throughput is 1 transfer per cycle.
  - FULL with y_ready_i=1 and no grant: -> EMPTY.
  - FULL with y_ready_i=0: hold y_data_o and sel_o; both readys are 0; the pointer does not change.
- Latency: one cycle from a requester handshake to y_valid_o.
- Fairness: under continuous requests from both, grants alternate A, B, A, B, ...
- Stall stability: while FULL and stalled, y_data_o and sel_o stay stable even if the requester inputs change.
- Reset mid-operation: any held byte is discarded, all state returns to reset values, and no handshake completes in that cycle (readys are forced to 0 while rst_i=1).

Decomposition:
- Package rr_mux_pkg:
  - typedef enum logic {SRC_A=1'b0, SRC_B=1'b1} src_e, used for the pointer, the grant and sel_o.
  - localparam DATA_W_DEF=8.
  - localparam CNT_W_DEF=16.
- One sub-module: rr_arb2, the combinational 2-way round-robin grant logic.
  - Inputs: req[1:0], last (src_e), en.
  - Outputs: gnt_valid, gnt (src_e).
  - The top level owns the registers, the mux and the counters.

Test Plan:
- Reset check: drive rst_i=1 for 2 cycles with a_valid_i=b_valid_i=1 -> a_ready_o=b_ready_o=0 and y_valid_o=0; on the first cycle after reset A is granted.
- Single requester: a_valid_i=1 with a_data_i=8'h3C, y_ready_i=1 -> a_ready_o=1; next cycle y_valid_o=1, y_data_o=8'h3C, sel_o=0, a_cnt_o=1.
- Contention: both valid continuously (A=8'hAA, B=8'h55), y_ready_i=1 for 4 cycles -> y_data_o sequence AA, 55, AA, 55; a_cnt_o=2, b_cnt_o=2.
- Back-pressure: output FULL with 8'hAA, y_ready_i=0 for 3 cycles while B requests -> y_data_o stays 8'hAA, b_ready_o=0; when y_ready_i rises, B is granted in that same cycle and y_data_o=8'h55 the next cycle.
- Saturation: run with CNT_W=2 and issue 5 A grants -> a_cnt_o reads 3 and stays at 3.
- Reset mid-operation: assert rst_i while FULL and stalled -> next cycle y_valid_o=0, counters=0, and on the first contention after reset A wins.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared types and defaults for the round-robin 2:1 mux arbiter.
package rr_mux_pkg;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant: on a tie, the requester that did not
// win last time is chosen.
module rr_arb2
    import rr_mux_pkg::*;
(
    input  logic [1:0] req,
    input  src_e       last,
    input  logic       en,
    output logic       gnt_valid,
    output src_e       gnt
);

    // req[0] is requester A, req[1] is requester B.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = SRC_A;
        if (en) begin
            unique case (req)
                2'b01: begin
                    gnt_valid = 1'b1;
                    gnt       = SRC_A;
                end
                2'b10: begin
                    gnt_valid = 1'b1;
                    gnt       = SRC_B;
                end
                2'b11: begin
                    gnt_valid = 1'b1;
                    gnt       = (last == SRC_A) ? SRC_B : SRC_A;
                end
                default: begin
                    gnt_valid = 1'b0;
                    gnt       = SRC_A;
                end
            endcase
        end
    end

endmodule

// File: rtl/rr_mux_arb.sv
// Round-robin arbiter steering two requesters through a 2:1 byte mux into a
// one-entry output register, with saturating per-requester grant counters.
module rr_mux_arb
    import rr_mux_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEF,
    parameter int CNT_W = CNT_W_DEF
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             a_valid_i,
    input  logic [WIDTH-1:0] a_data_i,
    output logic             a_ready_o,
    input  logic             b_valid_i,
    input  logic [WIDTH-1:0] b_data_i,
    output logic             b_ready_o,
    output logic             y_valid_o,
    output logic [WIDTH-1:0] y_data_o,
    input  logic             y_ready_i,
    output logic             sel_o,
    output logic [CNT_W-1:0] a_cnt_o,
    output logic [CNT_W-1:0] b_cnt_o
);

    logic             r_y_valid;
    logic [WIDTH-1:0] r_y_data;
    src_e             r_sel;
    src_e             r_last;

    logic             w_load_en;
    logic             w_gnt_valid;
    src_e             w_gnt;
    logic [1:0]       w_hit;
    logic [WIDTH-1:0] w_mux_data;

    // Reset gates the arbiter so no handshake can complete in a reset cycle.
    assign w_load_en = (!r_y_valid || y_ready_i) && !rst_i;

    rr_arb2 u_arb (
        .req       ({b_valid_i, a_valid_i}),
        .last      (r_last),
        .en        (w_load_en),
        .gnt_valid (w_gnt_valid),
        .gnt       (w_gnt)
    );

    assign w_hit[0]   = w_gnt_valid && (w_gnt == SRC_A);
    assign w_hit[1]   = w_gnt_valid && (w_gnt == SRC_B);
    assign w_mux_data = (w_gnt == SRC_B) ? b_data_i : a_data_i;

    assign a_ready_o = w_hit[0];
    assign b_ready_o = w_hit[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_y_valid <= 1'b0;
            r_y_data  <= '0;
            r_sel     <= SRC_A;
            r_last    <= SRC_B;
        end else if (w_gnt_valid) begin
            r_y_valid <= 1'b1;
            r_y_data  <= w_mux_data;
            r_sel     <= w_gnt;
            r_last    <= w_gnt;
        end else if (y_ready_i) begin
            r_y_valid <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;

            // Saturate at all-ones so long debug runs never wrap to a small value.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_cnt <= '0;
                end else if (w_hit[gi] && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    endgenerate

    assign a_cnt_o   = g_cnt[0].r_cnt;
    assign b_cnt_o   = g_cnt[1].r_cnt;
    assign y_valid_o = r_y_valid;
    assign y_data_o  = r_y_data;
    assign sel_o     = r_sel;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed testbench for rr_mux_arb: reset, single requester, contention,
// back-pressure, counter saturation (second instance) and mid-operation reset.
module tb_rr_mux_arb;

    logic        clk;
    logic        rst;
    logic        a_valid, b_valid, y_ready;
    logic [7:0]  a_data, b_data;
    logic        a_ready, b_ready, y_valid, sel;
    logic [7:0]  y_data;
    logic [15:0] a_cnt, b_cnt;

    logic        s_rst, s_a_valid, s_b_valid, s_y_ready;
    logic [7:0]  s_a_data, s_b_data, s_y_data;
    logic        s_a_ready, s_b_ready, s_y_valid, s_sel;
    logic [1:0]  s_a_cnt, s_b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    rr_mux_arb #(.WIDTH(8), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .a_valid_i(a_valid), .a_data_i(a_data), .a_ready_o(a_ready),
        .b_valid_i(b_valid), .b_data_i(b_data), .b_ready_o(b_ready),
        .y_valid_o(y_valid), .y_data_o(y_data), .y_ready_i(y_ready),
        .sel_o(sel), .a_cnt_o(a_cnt), .b_cnt_o(b_cnt)
    );

    rr_mux_arb #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(s_rst),
        .a_valid_i(s_a_valid), .a_data_i(s_a_data), .a_ready_o(s_a_ready),
        .b_valid_i(s_b_valid), .b_data_i(s_b_data), .b_ready_o(s_b_ready),
        .y_valid_o(s_y_valid), .y_data_o(s_y_data), .y_ready_i(s_y_ready),
        .sel_o(s_sel), .a_cnt_o(s_a_cnt), .b_cnt_o(s_b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; y_ready = 1'b1;
        a_data = 8'h12; b_data = 8'h34;
        for (int i = 0; i < 2; i++) begin
            step();
            n_tests++;
            if ({a_ready, b_ready} !== 2'b00) begin
                $display("FAIL reset_ready cyc%0d: got a=%b b=%b, want 0 0", i, a_ready, b_ready);
                n_fail++;
            end
        end
        n_tests++;
        if ({y_valid, y_data, sel, a_cnt, b_cnt} !== 42'd0) begin
            $display("FAIL reset_state: got v=%b d=%h s=%b ac=%0d bc=%0d, want all 0",
                     y_valid, y_data, sel, a_cnt, b_cnt);
            n_fail++;
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({a_ready, b_ready} !== 2'b10) begin
            $display("FAIL reset_first_tie: got a=%b b=%b, want 1 0", a_ready, b_ready);
            n_fail++;
        end
        $display("[TB] reset: readys held low, state cleared, A wins first tie");
        a_valid = 1'b0; b_valid = 1'b0;
        step();
    endtask

    task automatic test_single();
        a_valid = 1'b1; a_data = 8'h3C; b_valid = 1'b0; y_ready = 1'b1;
        #1;
        n_tests++;
        if ({a_ready, b_ready} !== 2'b10) begin
            $display("FAIL single_ready: got a=%b b=%b, want 1 0", a_ready, b_ready);
            n_fail++;
        end
        step();
        a_valid = 1'b0;
        n_tests++;
        if ({y_valid, y_data, sel} !== {1'b1, 8'h3C, 1'b0} || a_cnt !== 16'd1) begin
            $display("FAIL single_out: got v=%b d=%h s=%b ac=%0d, want 1 3c 0 1",
                     y_valid, y_data, sel, a_cnt);
            n_fail++;
        end
        $display("[TB] single: A 3c -> y=%h sel=%b a_cnt=%0d", y_data, sel, a_cnt);
        step();
        n_tests++;
        if (y_valid !== 1'b0) begin
            $display("FAIL single_drain: got y_valid=%b, want 0", y_valid);
            n_fail++;
        end
    endtask

    task automatic test_contention();
        logic [7:0] exp_d;
        logic       exp_s;
        rst = 1'b1;
        step();
        rst = 1'b0;
        a_valid = 1'b1; a_data = 8'hAA; b_valid = 1'b1; b_data = 8'h55; y_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_s = (i % 2 == 1);
            exp_d = exp_s ? 8'h55 : 8'hAA;
            #1;
            n_tests++;
            if ({a_ready, b_ready} !== {~exp_s, exp_s}) begin
                $display("FAIL contend_ready%0d: got a=%b b=%b, want %b %b",
                         i, a_ready, b_ready, ~exp_s, exp_s);
                n_fail++;
            end
            step();
            n_tests++;
            if ({y_valid, y_data, sel} !== {1'b1, exp_d, exp_s}) begin
                $display("FAIL contend_out%0d: got v=%b d=%h s=%b, want 1 %h %b",
                         i, y_valid, y_data, sel, exp_d, exp_s);
                n_fail++;
            end
            $display("[TB] contend %0d: y=%h sel=%b", i, y_data, sel);
        end
        a_valid = 1'b0; b_valid = 1'b0;
        n_tests++;
        if (a_cnt !== 16'd2 || b_cnt !== 16'd2) begin
            $display("FAIL contend_cnt: got a=%0d b=%0d, want 2 2", a_cnt, b_cnt);
            n_fail++;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] stall_b [3];
        stall_b[0] = 8'h11; stall_b[1] = 8'h22; stall_b[2] = 8'h33;
        a_valid = 1'b1; a_data = 8'hAA; b_valid = 1'b0; y_ready = 1'b1;
        step();
        a_valid = 1'b0; b_valid = 1'b1; y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_data = stall_b[i];
            a_data = stall_b[i] ^ 8'hFF;
            #1;
            n_tests++;
            if ({a_ready, b_ready} !== 2'b00) begin
                $display("FAIL stall_ready%0d: got a=%b b=%b, want 0 0", i, a_ready, b_ready);
                n_fail++;
            end
            step();
            n_tests++;
            if ({y_valid, y_data, sel} !== {1'b1, 8'hAA, 1'b0}) begin
                $display("FAIL stall_hold%0d: got v=%b d=%h s=%b, want 1 aa 0",
                         i, y_valid, y_data, sel);
                n_fail++;
            end
            $display("[TB] stall %0d: y=%h held", i, y_data);
        end
        b_data = 8'h55; y_ready = 1'b1;
        #1;
        n_tests++;
        if ({a_ready, b_ready} !== 2'b01) begin
            $display("FAIL release_ready: got a=%b b=%b, want 0 1", a_ready, b_ready);
            n_fail++;
        end
        step();
        b_valid = 1'b0;
        n_tests++;
        if ({y_valid, y_data, sel} !== {1'b1, 8'h55, 1'b1} || a_cnt !== 16'd3 || b_cnt !== 16'd3) begin
            $display("FAIL release_out: got v=%b d=%h s=%b ac=%0d bc=%0d, want 1 55 1 3 3",
                     y_valid, y_data, sel, a_cnt, b_cnt);
            n_fail++;
        end
        $display("[TB] release: y=%h sel=%b", y_data, sel);
    endtask

    task automatic test_saturation();
        logic [1:0] exp_c;
        s_rst = 1'b1;
        step();
        s_rst = 1'b0; s_a_valid = 1'b1; s_b_valid = 1'b0; s_y_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s_a_data = 8'(8'h40 + i);
            step();
            exp_c = (i >= 2) ? 2'd3 : 2'(i + 1);
            n_tests++;
            if (s_a_cnt !== exp_c || s_y_data !== 8'(8'h40 + i) || s_b_cnt !== 2'd0) begin
                $display("FAIL sat%0d: got ac=%0d bc=%0d d=%h, want %0d 0 %h",
                         i, s_a_cnt, s_b_cnt, s_y_data, exp_c, 8'(8'h40 + i));
                n_fail++;
            end
            $display("[TB] sat grant %0d: a_cnt=%0d", i, s_a_cnt);
        end
        s_a_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1; a_data = 8'h77; y_ready = 1'b0;
        step();
        rst = 1'b1; b_valid = 1'b1; b_data = 8'h99;
        #1;
        n_tests++;
        if ({a_ready, b_ready} !== 2'b00) begin
            $display("FAIL mid_rst_ready: got a=%b b=%b, want 0 0", a_ready, b_ready);
            n_fail++;
        end
        step();
        n_tests++;
        if ({y_valid, y_data, sel, a_cnt, b_cnt} !== 42'd0) begin
            $display("FAIL mid_rst_state: got v=%b d=%h s=%b ac=%0d bc=%0d, want all 0",
                     y_valid, y_data, sel, a_cnt, b_cnt);
            n_fail++;
        end
        rst = 1'b0; y_ready = 1'b1;
        #1;
        n_tests++;
        if ({a_ready, b_ready} !== 2'b10) begin
            $display("FAIL mid_rst_tie: got a=%b b=%b, want 1 0", a_ready, b_ready);
            n_fail++;
        end
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        n_tests++;
        if ({y_valid, y_data, sel} !== {1'b1, 8'h77, 1'b0} || a_cnt !== 16'd1) begin
            $display("FAIL mid_rst_out: got v=%b d=%h s=%b ac=%0d, want 1 77 0 1",
                     y_valid, y_data, sel, a_cnt);
            n_fail++;
        end
        $display("[TB] reset mid-op: y=%h sel=%b", y_data, sel);
    endtask

    initial begin
        rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
        a_data = 8'h00; b_data = 8'h00;
        s_rst = 1'b1; s_a_valid = 1'b0; s_b_valid = 1'b0; s_y_ready = 1'b0;
        s_a_data = 8'h00; s_b_data = 8'h00;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
